mem_copy_engine: RTL
====================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-002 SHALL have parameter MEM_SIZE, default 32: number of words in the target memory.
REQ-003 SHALL have localparam ADDR_WIDTH = $clog2(MEM_SIZE), 5 at default; not overridable.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-007 SHALL have port src_addr  input  ADDR_WIDTH  first source word address, latched on accepted start.
REQ-008 SHALL have port dst_addr  input  ADDR_WIDTH  first destination word address, latched on accepted start.
REQ-009 SHALL have port len  input  ADDR_WIDTH+1  word count, 0..MEM_SIZE, latched on accepted start.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a copy completes.
REQ-012 SHALL have port error  output  1  sticky readback-mismatch flag (REQ-031).
REQ-013 SHALL have port mem_write  output  1  write strobe to the memory write input.
REQ-014 SHALL have port mem_addr  output  ADDR_WIDTH  memory word address.
REQ-015 SHALL have port mem_wdata  output  WIDTH  memory write data.
REQ-016 SHALL have port mem_rdata  input  WIDTH  memory read data, combinational from mem_addr.

Function
REQ-017 SHALL be an initiator for a single-port memory: combinational read of mem_addr, write of mem_wdata at the clock edge where mem_write=1.
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, CHECK, DONE.
REQ-019 SHALL, in IDLE with start=1, latch src/dst/len, clear word index i to 0, go to READ; with len=0, go directly to DONE.
REQ-020 SHALL ignore start in any state other than IDLE.
REQ-021 SHALL, in READ, drive mem_addr=src+i, mem_write=0, capture mem_rdata into a WIDTH-bit data buffer, go to WRITE.
REQ-022 SHALL, in WRITE, drive mem_addr=dst+i, mem_wdata=buffer, mem_write=1; then go to CHECK if REQ-031 is enabled, else increment i.
REQ-023 SHALL, after i is incremented, go to DONE if i==len, else to READ.
REQ-024 SHALL compute addresses modulo 2^ADDR_WIDTH, so src+i and dst+i wrap from MEM_SIZE-1 to 0.
REQ-025 SHALL copy in ascending order only; overlapping ranges with dst>src SHALL give forward-propagation results, with no memmove correction.
REQ-026 SHALL take exactly 2 cycles per word (3 with REQ-031), plus 1 DONE cycle; len=N SHALL assert busy for 2N+1 cycles.
REQ-027 SHALL pulse done=1 for exactly the one DONE cycle, then return to IDLE; start in that DONE cycle SHALL be ignored.
REQ-028 SHALL hold mem_write=0 in every state except WRITE.

Reset
REQ-029 SHALL, on rst=1, immediately force state=IDLE, busy=0, done=0, error=0, mem_write=0, mem_addr=0, mem_wdata=0, i=0, buffer=0.
REQ-030 SHALL, on reset during a copy, abandon the copy with no further write; words already written SHALL stay written.

Configuration
REQ-031 SHALL compile in readback verification only when macro MEM_COPY_CHECK_EN is defined: CHECK drives mem_addr=dst+i, mem_write=0, sets error=1 if mem_rdata!=buffer, then increments i; error SHALL clear only on reset or an accepted start.
REQ-032 SHALL, without MEM_COPY_CHECK_EN, omit the CHECK state and tie error to 0.

Structure
REQ-033 SHALL take the FSM state enum and the default WIDTH/MEM_SIZE constants from shared package mem_pkg.
REQ-034 SHALL need no sub-module; it is a single FSM plus datapath.

Verification
REQ-035 SHALL, with mem[0..3]=A0..A3, start with src=0 dst=8 len=4 -> mem[8..11]=A0..A3, done at cycle 9 after start, busy for 9 cycles.
REQ-036 SHALL, with src=30 dst=2 len=4 -> mem[2..5]=mem[30],mem[31],mem[0],mem[1] (wrap).
REQ-037 SHALL, with len=0 -> no mem_write, done pulses on the next cycle.
REQ-038 SHALL, with start pulsed again while busy -> ignored; only the first copy's writes appear.
REQ-039 SHALL, with rst asserted after the 2nd write of a len=6 copy -> exactly 2 destination words changed, all outputs at reset values.
REQ-040 SHALL, with MEM_COPY_CHECK_EN and the destination word forced stuck -> error=1 sticky until the next start.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state encoding and default sizes for mem_copy_engine.
// The CHECK state exists only when MEM_COPY_CHECK_EN is defined.
package mem_pkg;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_MEM_SIZE = 32;
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
`ifdef MEM_COPY_CHECK_EN
        CHECK,
`endif
        DONE
    } state_t;
endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-by-word ascending copy within a single-port memory.
// Define MEM_COPY_CHECK_EN to add a readback CHECK pass with a sticky error flag.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MEM_SIZE = DEF_MEM_SIZE,
    localparam int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);
    state_t                state;
    logic [ADDR_WIDTH-1:0] src_r, dst_r;
    logic [ADDR_WIDTH:0]   len_r, i, i_nxt;
    logic [WIDTH-1:0]      buffer;
    logic                  last;

    assign i_nxt     = i + (ADDR_WIDTH+1)'(1);
    assign last      = i_nxt == len_r;
    assign mem_wdata = buffer;

`ifdef MEM_COPY_CHECK_EN
    logic error_r;
    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    // Outputs are registered, so mem_addr is loaded on the edge entering each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            buffer    <= '0;
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= '0;
            i         <= '0;
`ifdef MEM_COPY_CHECK_EN
            error_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    src_r    <= src_addr;
                    dst_r    <= dst_addr;
                    len_r    <= len;
                    i        <= '0;
                    busy     <= 1'b1;
                    done     <= len == '0;
                    state    <= len == '0 ? DONE : READ;
                    mem_addr <= src_addr;
`ifdef MEM_COPY_CHECK_EN
                    error_r  <= 1'b0;
`endif
                end
                READ: begin
                    buffer    <= mem_rdata;
                    mem_addr  <= dst_r + i[ADDR_WIDTH-1:0];
                    mem_write <= 1'b1;
                    state     <= WRITE;
                end
`ifdef MEM_COPY_CHECK_EN
                WRITE: begin
                    mem_write <= 1'b0;
                    state     <= CHECK;
                end
                CHECK: begin
                    if (mem_rdata != buffer) error_r <= 1'b1;
                    i        <= i_nxt;
                    done     <= last;
                    state    <= last ? DONE : READ;
                    mem_addr <= src_r + i_nxt[ADDR_WIDTH-1:0];
                end
`else
                WRITE: begin
                    mem_write <= 1'b0;
                    i         <= i_nxt;
                    done      <= last;
                    state     <= last ? DONE : READ;
                    mem_addr  <= src_r + i_nxt[ADDR_WIDTH-1:0];
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
